hub75_bitplane_shifter: RTL and testbench

- Upstream neighbour of the RGB delay line. It scans a HUB75-style panel chain row by row and bit-plane by bit-plane using Binary Code Modulation (BCM).
- Reads packed pixel words from the line buffer, slices out the current bit-plane, and drives 3-lane R/G/B serial data plus a matching shift enable. These outputs feed the delay line's data and clock-enable inputs directly.
- Generates LAT, OE_N and ROW_ADDR for the physical panels.

---
 rtl/hub75_pkg.sv | 27 ++
 rtl/bcm_on_timer.sv | 40 ++++
 rtl/hub75_bitplane_shifter.sv | 189 ++++++++++++++++++
 tb/tb_hub75_bitplane_shifter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 bit-plane scanner.
package hub75_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShift,
    StBlank,
    StLatch,
    StDisplay
  } state_e;

  localparam int unsigned LANES    = 3;
  // Lane offsets inside the RD_DATA word, packed {B2..B0, G2..G0, R2..R0}
  localparam int unsigned R_OFFSET = 0;
  localparam int unsigned G_OFFSET = LANES;
  localparam int unsigned B_OFFSET = 2 * LANES;

  // Bits needed to hold the longest on-time, BASE_TIME << (DEPTH-1)
  function automatic int unsigned on_time_width(input int unsigned base_time,
                                                input int unsigned depth);
    int unsigned w;
    w = $clog2((base_time << (depth - 1)) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bcm_on_timer.sv
// BCM on-time down-counter: loads BASE_TIME << plane, counts to zero, flags done.
module bcm_on_timer
  import hub75_pkg::*;
#(
  parameter int unsigned BASE_TIME = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PLANE_W   = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [PLANE_W-1:0] plane_i,
  output logic               done_o
);

  localparam int unsigned CntW = on_time_width(BASE_TIME, DEPTH);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Loaded with N-1 so that done is seen on the N-th cycle after the load
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'((BASE_TIME << plane_i) - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hub75_bitplane_shifter.sv
// HUB75 BCM row/plane scanner: fetches pixels, shifts one bit-plane out, drives LAT/OE_N/ROW_ADDR.
// Define HUB75_GHOST_BLANK_EN to add BLANK_CYCLES of OE_N=1 after the last plane of each row.
module hub75_bitplane_shifter
  import hub75_pkg::*;
#(
  parameter int unsigned COLS         = 128,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ROW_BITS     = 4,
  parameter int unsigned BASE_TIME    = 4,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             ENABLE,
  output logic [$clog2(COLS)+ROW_BITS-1:0] RD_ADDR,
  input  logic [9*DEPTH-1:0]               RD_DATA,
  output logic [LANES-1:0]                 OUT_R,
  output logic [LANES-1:0]                 OUT_G,
  output logic [LANES-1:0]                 OUT_B,
  output logic                             SHIFT_ENA,
  output logic                             LAT,
  output logic                             OE_N,
  output logic [ROW_BITS-1:0]              ROW_ADDR,
  output logic                             FRAME_DONE
);

  localparam int unsigned ColW   = $clog2(COLS);
  localparam int unsigned PlaneW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BlankW = $clog2(BLANK_CYCLES + 1);

  state_e              state_q, state_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [BlankW-1:0]   blank_q, blank_d;
  logic [PlaneW-1:0]   plane_q, plane_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic                shift_ena_q, shift_ena_d;
  logic [LANES-1:0]    out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
  logic                frame_done_q, frame_done_d;
  logic                ghost_q, ghost_d;
  logic                timer_done;
  logic [3*LANES-1:0]  plane_bit;

  for (genvar l = 0; l < 3 * LANES; l++) begin : g_lane
    logic [DEPTH-1:0] lane_bits;
    assign lane_bits    = RD_DATA[l*DEPTH +: DEPTH];
    assign plane_bit[l] = lane_bits[plane_q];
  end

  bcm_on_timer #(
    .BASE_TIME(BASE_TIME),
    .DEPTH    (DEPTH),
    .PLANE_W  (PlaneW)
  ) u_on_timer (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .load_i (state_q == StLatch),
    .plane_i(plane_q),
    .done_o (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    blank_d      = blank_q;
    plane_d      = plane_q;
    row_d        = row_q;
    row_addr_d   = row_addr_q;
    rd_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    ghost_d      = ghost_q;

    unique case (state_q)
      StIdle: begin
        if (ENABLE) state_d = StFetch;
      end
      StFetch: begin
        rd_valid_d = 1'b1;
        if (col_q == ColW'(COLS - 1)) begin
          col_d   = '0;
          state_d = StShift;
        end else begin
          col_d = col_q + ColW'(1);
        end
      end
      StShift: begin
        // Leave once the last fetched beat has been registered
        if (!rd_valid_q) begin
          state_d    = StBlank;
          blank_d    = '0;
          ghost_d    = 1'b0;
          row_addr_d = row_q;
        end
      end
      StBlank: begin
        if (blank_q == BlankW'(BLANK_CYCLES - 1)) begin
          blank_d = '0;
          ghost_d = 1'b0;
          state_d = ghost_q ? StFetch : StLatch;
        end else begin
          blank_d = blank_q + BlankW'(1);
        end
      end
      StLatch: begin
        state_d = StDisplay;
      end
      StDisplay: begin
        if (timer_done) begin
          if (plane_q != PlaneW'(DEPTH - 1)) begin
            plane_d = plane_q + PlaneW'(1);
            state_d = StFetch;
          end else begin
            plane_d      = '0;
            row_d        = row_q + ROW_BITS'(1);
            frame_done_d = (row_q == '1);
            if ((row_q == '1) && !ENABLE) begin
              state_d = StIdle;
            end else begin
`ifdef HUB75_GHOST_BLANK_EN
              state_d = StBlank;
              blank_d = '0;
              ghost_d = 1'b1;
`else
              state_d = StFetch;
`endif
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_ena_d = rd_valid_q;
    out_r_d     = out_r_q;
    out_g_d     = out_g_q;
    out_b_d     = out_b_q;
    if (rd_valid_q) begin
      out_r_d = plane_bit[R_OFFSET +: LANES];
      out_g_d = plane_bit[G_OFFSET +: LANES];
      out_b_d = plane_bit[B_OFFSET +: LANES];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      col_q        <= '0;
      blank_q      <= '0;
      plane_q      <= '0;
      row_q        <= '0;
      row_addr_q   <= '0;
      rd_valid_q   <= 1'b0;
      shift_ena_q  <= 1'b0;
      out_r_q      <= '0;
      out_g_q      <= '0;
      out_b_q      <= '0;
      frame_done_q <= 1'b0;
      ghost_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      blank_q      <= blank_d;
      plane_q      <= plane_d;
      row_q        <= row_d;
      row_addr_q   <= row_addr_d;
      rd_valid_q   <= rd_valid_d;
      shift_ena_q  <= shift_ena_d;
      out_r_q      <= out_r_d;
      out_g_q      <= out_g_d;
      out_b_q      <= out_b_d;
      frame_done_q <= frame_done_d;
      ghost_q      <= ghost_d;
    end
  end

  assign RD_ADDR    = {row_q, col_q};
  assign OUT_R      = out_r_q;
  assign OUT_G      = out_g_q;
  assign OUT_B      = out_b_q;
  assign SHIFT_ENA  = shift_ena_q;
  assign LAT        = (state_q == StLatch);
  assign OE_N       = (state_q != StDisplay);
  assign ROW_ADDR   = row_addr_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_hub75_bitplane_shifter.sv
// Directed bench for hub75_bitplane_shifter with COLS=4, DEPTH=2, ROW_BITS=1, BASE_TIME=3, BLANK=2.
module tb_hub75_bitplane_shifter;

`ifdef HUB75_GHOST_BLANK_EN
  localparam int GHOST = 2;
`else
  localparam int GHOST = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  rd_addr;
  logic [17:0] rd_data = '0;
  logic [2:0]  out_r, out_g, out_b;
  logic        shift_ena, lat, oe_n, frame_done;
  logic [0:0]  row_addr;

  logic [17:0] mem [8];
  int          checks = 0;
  int          failures = 0;
  int          prev_row;
  logic        fd_pending;

  // One record per (row, plane) scan segment; exp_bgr[c] = {OUT_B, OUT_G, OUT_R} for column c
  typedef struct {
    int              row;
    int              plane;
    int              on_len;
    logic [3:0][8:0] exp_bgr;
  } seg_t;
  seg_t segs [4];

  hub75_bitplane_shifter #(
    .COLS        (4),
    .DEPTH       (2),
    .ROW_BITS    (1),
    .BASE_TIME   (3),
    .BLANK_CYCLES(2)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .ENABLE    (enable),
    .RD_ADDR   (rd_addr),
    .RD_DATA   (rd_data),
    .OUT_R     (out_r),
    .OUT_G     (out_g),
    .OUT_B     (out_b),
    .SHIFT_ENA (shift_ena),
    .LAT       (lat),
    .OE_N      (oe_n),
    .ROW_ADDR  (row_addr),
    .FRAME_DONE(frame_done)
  );

  always #5 clk = ~clk;

  // Line buffer with one cycle of read latency
  always @(posedge clk) rd_data <= mem[rd_addr];

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".out_r"}, 32'(out_r), 0);
    chk({tag, ".out_g"}, 32'(out_g), 0);
    chk({tag, ".out_b"}, 32'(out_b), 0);
    chk({tag, ".shift_ena"}, 32'(shift_ena), 0);
    chk({tag, ".lat"}, 32'(lat), 0);
    chk({tag, ".oe_n"}, 32'(oe_n), 1);
    chk({tag, ".row_addr"}, 32'(row_addr), 0);
    chk({tag, ".rd_addr"}, 32'(rd_addr), 0);
    chk({tag, ".frame_done"}, 32'(frame_done), 0);
  endtask

  // Walks one segment cycle by cycle; k=0 is the first FETCH cycle
  task automatic run_segment(input int s, input int ghost, input bit frame_end);
    int         len;
    int         on_end;
    string      tag;
    logic [1:0] ci;
    bit         exp_fd;
    len    = 9 + segs[s].on_len + ghost;
    on_end = 9 + segs[s].on_len;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      tag = $sformatf("r%0dp%0d.k%0d", segs[s].row, segs[s].plane, k);
      if (k < 4) chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(segs[s].row * 4 + k));
      chk({tag, ".shift_ena"}, 32'(shift_ena), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        ci = 2'(k - 2);
        chk({tag, ".out_bgr"}, 32'({out_b, out_g, out_r}), 32'(segs[s].exp_bgr[ci]));
      end else if (k > 5) begin
        chk({tag, ".out_hold"}, 32'({out_b, out_g, out_r}), 32'(segs[s].exp_bgr[3]));
      end
      chk({tag, ".lat"}, 32'(lat), 32'(k == 8));
      chk({tag, ".oe_n"}, 32'(oe_n), 32'(!(k >= 9 && k < on_end)));
      chk({tag, ".row_addr"}, 32'(row_addr), 32'((k >= 6) ? segs[s].row : prev_row));
      exp_fd = (k == 0 && fd_pending) || (frame_end && k == on_end);
      chk({tag, ".frame_done"}, 32'(frame_done), 32'(exp_fd));
    end
    prev_row   = segs[s].row;
    fd_pending = frame_end && (ghost == 0);
  endtask

  task automatic run_frame(input bit drop_enable);
    run_segment(0, 0, 1'b0);
    if (drop_enable) enable = 1'b0;
    run_segment(1, GHOST, 1'b0);
    run_segment(2, 0, 1'b0);
    run_segment(3, drop_enable ? 0 : GHOST, 1'b1);
  endtask

  initial begin
    logic [17:0] w;
    int          n;

    // R0 lane: row0=01, row1=10; G1 lane = column index; B2 lane: row0=11, row1=00
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        w          = '0;
        w[1:0]     = (r == 0) ? 2'b01 : 2'b10;
        w[9:8]     = 2'(c);
        w[17:16]   = (r == 0) ? 2'b11 : 2'b00;
        mem[r*4+c] = w;
      end
    end

    segs[0] = '{0, 0, 3, {9'b100_010_001, 9'b100_000_001, 9'b100_010_001, 9'b100_000_001}};
    segs[1] = '{0, 1, 6, {9'b100_010_000, 9'b100_010_000, 9'b100_000_000, 9'b100_000_000}};
    segs[2] = '{1, 0, 3, {9'b000_010_000, 9'b000_000_000, 9'b000_010_000, 9'b000_000_000}};
    segs[3] = '{1, 1, 6, {9'b000_010_001, 9'b000_010_001, 9'b000_000_001, 9'b000_000_001}};

    fd_pending = 1'b0;
    prev_row   = 0;

    // Reset held 3 cycles with ENABLE high
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    // Two full frames; ENABLE dropped during row 0 of the second
    run_frame(1'b0);
    run_frame(1'b1);

    // Stopped in IDLE: panel dark, no fetch activity
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d.oe_n", i), 32'(oe_n), 1);
      chk($sformatf("idle%0d.lat", i), 32'(lat), 0);
      chk($sformatf("idle%0d.shift_ena", i), 32'(shift_ena), 0);
      chk($sformatf("idle%0d.rd_addr", i), 32'(rd_addr), 0);
      chk($sformatf("idle%0d.row_addr", i), 32'(row_addr), 1);
      chk($sformatf("idle%0d.frame_done", i), 32'(frame_done), 32'(i == 0 && fd_pending));
    end

    // Restart, then reset in the middle of DISPLAY
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (oe_n !== 1'b0 && n < 60);
    chk("wait_display.oe_n", 32'(oe_n), 0);
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("mid_reset");
    @(negedge clk);
    rst_n      = 1'b1;
    fd_pending = 1'b0;
    prev_row   = 0;
    run_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
